// File: rtl/knn_pkg.sv
// Shared definitions for the k-NN batch sequencer: FSM state encoding,
// default point/label widths and the x/y field positions inside a point word.
package knn_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LABEL_DEF  = 8;

    // A point word packs x in the upper half and y in the lower half.
    localparam int X_MSB = 31;
    localparam int X_LSB = 16;
    localparam int Y_MSB = 15;
    localparam int Y_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/knn_sched_ctr.sv
// Loadable up-counter with an equality terminal-count flag.
// Used for the training index, the test index and the drain delay.
module knn_sched_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic [W-1:0] i_tc,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Count register: load wins over increment.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_inc)  r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_tc);

endmodule

// File: rtl/knn_sched.sv
// Batch sequencer for one knn_core: per test point it loads the point,
// clears the core's list, streams all training points as one contiguous
// burst, waits for the list to settle and hands the result to a consumer.
module knn_sched
    import knn_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LABEL     = LABEL_DEF,
    parameter int TRAIN_AW  = 10,
    parameter int TEST_AW   = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [TRAIN_AW:0]   n_train,
    input  logic [TEST_AW:0]    n_test,
    output logic                busy,
    output logic                done,
    output logic                te_en,
    output logic [TEST_AW-1:0]  te_addr,
    input  logic [DATA_W-1:0]   te_data,
    output logic                tr_en,
    output logic [TRAIN_AW-1:0] tr_addr,
    input  logic [DATA_W-1:0]   tr_data,
    input  logic [LABEL-1:0]    tr_label,
    output logic [DATA_W-1:0]   knn_A,
    output logic [DATA_W-1:0]   knn_B,
    output logic [LABEL-1:0]    knn_label,
    output logic                knn_valid,
    output logic                knn_start,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [TEST_AW-1:0]  res_idx
);

    localparam int DW       = $clog2(DRAIN_CYC + 1) + 1;
    localparam int DRAIN_TC = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    state_t              r_state;
    logic [TRAIN_AW:0]   r_n_train;
    logic [TEST_AW:0]    r_n_test;
    logic                r_busy, r_done, r_te_en, r_tr_en;
    logic                r_knn_valid, r_knn_start, r_res_valid;
    logic [TEST_AW-1:0]  r_te_addr;
    logic [TRAIN_AW-1:0] r_tr_addr;
    logic [DATA_W-1:0]   r_knn_a;

    logic [TRAIN_AW:0]   w_i;
    logic                w_i_tc;
    logic [TEST_AW:0]    w_t, w_t_next, w_t_last;
    logic                w_t_tc;
    logic [DW-1:0]       w_drain_cnt_unused;
    logic                w_d_tc;
    logic                w_streaming, w_last_beat, w_handshake;

    assign w_streaming = (r_state == S_CLEAR) || (r_state == S_STREAM);
    // The beat on the bus now is the final one when no further read is issued.
    assign w_last_beat = (r_state == S_STREAM) && r_knn_valid && !r_tr_en;
    assign w_handshake = (r_state == S_RESULT) && res_ready;
    assign w_t_next    = w_t + 1'b1;
    assign w_t_last    = r_n_test - 1'b1;

    // Training index: starts at 1 since address 0 is issued from LOAD.
    knn_sched_ctr #(.W(TRAIN_AW + 1)) u_ctr_i (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == S_LOAD),
        .i_load_val ({{TRAIN_AW{1'b0}}, 1'b1}),
        .i_inc      (w_streaming && !w_i_tc),
        .i_tc       (r_n_train),
        .o_cnt      (w_i),
        .o_tc       (w_i_tc)
    );

    // Test index: terminal count flags the last test point of the batch.
    knn_sched_ctr #(.W(TEST_AW + 1)) u_ctr_t (
        .clk        (clk),
        .rst        (rst),
        .i_load     ((r_state == S_IDLE) && go),
        .i_load_val ('0),
        .i_inc      (w_handshake),
        .i_tc       (w_t_last),
        .o_cnt      (w_t),
        .o_tc       (w_t_tc)
    );

    // Drain delay covering the core's list insertion latency.
    knn_sched_ctr #(.W(DW)) u_ctr_d (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_last_beat),
        .i_load_val ('0),
        .i_inc      (r_state == S_DRAIN),
        .i_tc       (DW'(DRAIN_TC)),
        .o_cnt      (w_drain_cnt_unused),
        .o_tc       (w_d_tc)
    );

    // Sequencer FSM with registered outputs for memories, core and consumer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_n_train   <= '0;
            r_n_test    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_te_en     <= 1'b0;
            r_te_addr   <= '0;
            r_tr_en     <= 1'b0;
            r_tr_addr   <= '0;
            r_knn_a     <= '0;
            r_knn_valid <= 1'b0;
            r_knn_start <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            // Read data arrives one cycle after the enable.
            r_knn_valid <= r_tr_en;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_n_train <= n_train;
                        r_n_test  <= n_test;
                        r_busy    <= 1'b1;
                        if (n_train == '0 || n_test == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_te_en   <= 1'b1;
                            r_te_addr <= '0;
                            r_state   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    r_te_en     <= 1'b0;
                    r_knn_start <= 1'b1;
                    r_tr_en     <= 1'b1;
                    r_tr_addr   <= '0;
                    r_state     <= S_CLEAR;
                end
                S_CLEAR, S_STREAM: begin
                    if (r_state == S_CLEAR) begin
                        r_knn_a     <= te_data;
                        r_knn_start <= 1'b0;
                        r_state     <= S_STREAM;
                    end
                    r_tr_en <= !w_i_tc;
                    if (!w_i_tc) r_tr_addr <= TRAIN_AW'(w_i);
                    if (w_last_beat) begin
                        if (DRAIN_CYC == 0) begin
                            r_res_valid <= 1'b1;
                            r_state     <= S_RESULT;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_d_tc) begin
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_t_tc) begin
                            r_done  <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_te_en   <= 1'b1;
                            r_te_addr <= TEST_AW'(w_t_next);
                            r_state   <= S_LOAD;
                        end
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign te_en     = r_te_en;
    assign te_addr   = r_te_addr;
    assign tr_en     = r_tr_en;
    assign tr_addr   = r_tr_addr;
    assign knn_A     = r_knn_a;
    assign knn_valid = r_knn_valid;
    assign knn_start = r_knn_start;
    // Candidate data is gated so the core never sees stale memory output.
    assign knn_B     = r_knn_valid ? tr_data  : '0;
    assign knn_label = r_knn_valid ? tr_label : '0;
    assign res_valid = r_res_valid;
    assign res_idx   = TEST_AW'(w_t);

endmodule

// File: tb/tb_knn_sched.sv
// Scoreboard bench for knn_sched: stimulus pushes expected beats/results
// derived from the batch rules; a negedge monitor pops and compares.
module tb_knn_sched;
    import knn_pkg::*;

    localparam int DATA_W = 32, LABEL = 8, TRAIN_AW = 10, TEST_AW = 8, DRAIN_CYC = 2;

    logic clk = 0, rst = 0, go = 0, res_ready = 0;
    logic [TRAIN_AW:0] n_train = '0;
    logic [TEST_AW:0] n_test = '0;
    logic busy, done, te_en, tr_en, knn_valid, knn_start, res_valid;
    logic [TEST_AW-1:0] te_addr, res_idx;
    logic [TRAIN_AW-1:0] tr_addr;
    logic [DATA_W-1:0] te_data, tr_data, knn_A, knn_B;
    logic [LABEL-1:0] tr_label, knn_label;

    knn_sched #(.DATA_W(DATA_W), .LABEL(LABEL), .TRAIN_AW(TRAIN_AW),
                .TEST_AW(TEST_AW), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .rst(rst), .go(go), .n_train(n_train), .n_test(n_test),
        .busy(busy), .done(done), .te_en(te_en), .te_addr(te_addr),
        .te_data(te_data), .tr_en(tr_en), .tr_addr(tr_addr), .tr_data(tr_data),
        .tr_label(tr_label), .knn_A(knn_A), .knn_B(knn_B), .knn_label(knn_label),
        .knn_valid(knn_valid), .knn_start(knn_start), .res_valid(res_valid),
        .res_ready(res_ready), .res_idx(res_idx)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] te_mem [0:(1<<TEST_AW)-1];
    logic [DATA_W-1:0] tr_mem [0:(1<<TRAIN_AW)-1];
    logic [LABEL-1:0]  lb_mem [0:(1<<TRAIN_AW)-1];

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (te_en) te_data <= te_mem[te_addr];
        if (tr_en) begin
            tr_data  <= tr_mem[tr_addr];
            tr_label <= lb_mem[tr_addr];
        end
    end

    typedef struct { logic [DATA_W-1:0] a; logic [DATA_W-1:0] b; logic [LABEL-1:0] lbl; } beat_t;
    beat_t beat_q[$];
    int    res_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, go_cyc = 0, cur_ntr = 0, act_cnt = 0, done_cnt = 0;
    int first_start_rel = -1, first_res_rel = -1, done_rel = -1;
    int ready_mode = 0, hold_cnt = 0;
    int run_left = 0, exp_tr = 0;
    logic prev_rv = 0, prev_rr = 0;
    logic [TEST_AW-1:0] prev_idx = '0;
    bit batch_end;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: always ready, random ready, or stall the first result 4 cycles.
    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0: res_ready = 1'b1;
            1: res_ready = 1'($urandom % 2);
            default: begin
                if (res_valid && hold_cnt < 4) begin
                    res_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    res_ready = (hold_cnt >= 4);
                end
            end
        endcase
    end

    // Monitor: protocol checks every cycle, scoreboard pops on beats/results.
    always @(negedge clk) begin
        if (!rst) begin
            run_left = 0; exp_tr = 0; prev_rv = 0; prev_rr = 0;
        end else begin
            automatic int rel = cyc - go_cyc;
            if (te_en | tr_en | knn_start | knn_valid) act_cnt++;
            if (knn_start && first_start_rel < 0) first_start_rel = rel;
            if (res_valid && first_res_rel < 0) first_res_rel = rel;
            if (done) begin done_cnt++; done_rel = rel; end
            check("start_valid_excl", 64'(knn_start & knn_valid), 0);
            check("valid_contig", 64'(knn_valid), 64'(run_left > 0));
            if (!knn_valid) begin
                check("gate_zero", {knn_B, knn_label}, 0);
            end else if (beat_q.size() == 0) begin
                check("beat_unexpected", 1, 0);
            end else begin
                automatic beat_t b = beat_q.pop_front();
                check("beat_A", knn_A, b.a);
                check("beat_B", knn_B, b.b);
                check("beat_label", knn_label, b.lbl);
            end
            if (run_left > 0) run_left--;
            if (knn_start) begin
                check("start_addr", {tr_en, tr_addr}, {1'b1, {TRAIN_AW{1'b0}}});
                exp_tr = 1;
                run_left = cur_ntr;
            end else if (tr_en) begin
                check("tr_addr", tr_addr, exp_tr);
                exp_tr++;
            end
            check("no_te_in_result", 64'(res_valid & te_en), 0);
            if (prev_rv && !prev_rr) check("res_hold", {res_valid, res_idx}, {1'b1, prev_idx});
            if (res_valid && res_ready) begin
                if (res_q.size() == 0) check("res_unexpected", 1, 0);
                else check("res_idx", res_idx, res_q.pop_front());
            end
            prev_rv = res_valid; prev_rr = res_ready; prev_idx = res_idx;
        end
    end

    // Reference model: every test point sees every training point in order.
    task automatic push_expect(input int ntr, input int nte);
        if (ntr == 0 || nte == 0) return;
        for (int t = 0; t < nte; t++) begin
            for (int k = 0; k < ntr; k++) begin
                automatic beat_t b;
                b.a = te_mem[t]; b.b = tr_mem[k]; b.lbl = lb_mem[k];
                beat_q.push_back(b);
            end
            res_q.push_back(t);
        end
    endtask

    task automatic start_go(input int ntr, input int nte);
        cur_ntr = ntr; act_cnt = 0; hold_cnt = 0;
        first_start_rel = -1; first_res_rel = -1; done_rel = -1;
        @(posedge clk); #1;
        n_train = (TRAIN_AW+1)'(ntr); n_test = (TEST_AW+1)'(nte);
        go = 1; go_cyc = cyc;
        @(posedge clk); #1;
        go = 0;
        n_train = (TRAIN_AW+1)'($urandom); n_test = (TEST_AW+1)'($urandom);
    endtask

    task automatic run_batch(input int ntr, input int nte, input int mode, input bit noise);
        automatic int d0 = done_cnt;
        automatic int budget = (ntr + 40) * (nte + 1) * 3 + 100;
        ready_mode = mode;
        push_expect(ntr, nte);
        start_go(ntr, nte);
        batch_end = 0;
        fork
            begin
                for (int c = 0; c < budget && done_cnt == d0; c++) @(posedge clk);
                batch_end = 1;
            end
            begin
                while (!batch_end) begin
                    @(posedge clk); #1;
                    if (noise && busy && ($urandom % 3 == 0)) begin
                        go = 1;
                        n_train = (TRAIN_AW+1)'($urandom);
                        n_test  = (TEST_AW+1)'($urandom);
                    end else begin
                        go = 0;
                    end
                end
                go = 0;
            end
        join
        repeat (3) @(posedge clk); #1;
        check("done_count", done_cnt, d0 + 1);
        check("beats_left", beat_q.size(), 0);
        check("results_left", res_q.size(), 0);
        check("idle_after", 64'(busy), 0);
        if (ntr == 0 || nte == 0) begin
            check("zero_done_cyc", done_rel, 1);
            check("zero_no_activity", act_cnt, 0);
        end else begin
            check("start_cyc", first_start_rel, 2);
            check("first_res_cyc", first_res_rel, 3 + ntr + DRAIN_CYC);
        end
        beat_q.delete(); res_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1<<TEST_AW); i++) te_mem[i] = $urandom;
        for (int i = 0; i < (1<<TRAIN_AW); i++) begin
            tr_mem[i] = $urandom;
            lb_mem[i] = LABEL'($urandom);
        end
        repeat (2) @(posedge clk); #1;
        check("rst_outputs", {busy, done, te_en, te_addr, tr_en, tr_addr, knn_valid,
                              knn_start, res_valid, res_idx}, 0);
        check("rst_data", {knn_A, knn_B, knn_label}, 0);
        rst = 1;

        // Single test point with exact cycle positions.
        run_batch(3, 1, 0, 0);
        check("t1_done_cyc", done_rel, 9);

        // Stalled first result, then a second burst.
        run_batch(4, 2, 2, 0);

        // Zero counts.
        run_batch(0, 3, 0, 0);
        run_batch(6, 0, 0, 0);

        // Spurious go pulses while busy and during RESULT.
        run_batch(5, 3, 1, 1);
        run_batch(2, 2, 2, 1);

        // Async reset in the middle of a burst.
        begin
            automatic int d0;
            automatic bit seen = 0;
            push_expect(5, 1);
            ready_mode = 0;
            start_go(5, 1);
            for (int c = 0; c < 50 && !seen; c++) begin
                if (tr_en && tr_addr == 2) seen = 1;
                else begin @(posedge clk); #1; end
            end
            check("reach_i2", 64'(seen), 1);
            #2 rst = 0;
            #1;
            check("async_rst_outputs", {busy, done, te_en, te_addr, tr_en, tr_addr, knn_valid,
                                        knn_start, res_valid, res_idx}, 0);
            check("async_rst_data", {knn_A, knn_B, knn_label}, 0);
            beat_q.delete(); res_q.delete();
            d0 = done_cnt;
            repeat (3) @(posedge clk); #3;
            rst = 1;
            repeat (2) @(posedge clk); #1;
            check("abort_no_done", done_cnt, d0);
            run_batch(5, 1, 0, 0);
        end

        // Randomised batches.
        for (int r = 0; r < 6; r++)
            run_batch($urandom_range(1, 24), $urandom_range(1, 4), $urandom_range(0, 2),
                      1'($urandom % 2));

        // Full-size training burst.
        run_batch(1 << TRAIN_AW, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_sched.md
Name: knn_sched

Overview:
- Sequencer that drives one knn_core instance across a batch of test points.
- Per test point: fetches the test point, pulses the core's start to clear its neighbour list, then streams every training point/label from a training memory as one contiguous burst of valid cycles.
- Waits for the list to settle, then offers the result to a consumer with a valid/ready handshake.
- Sits between the register bank (config, go/done) and knn_core plus its two point memories.

Parameters:
- DATA_W, 32, point width; x in [31:16], y in [15:0].
- LABEL, 8, label width.
- TRAIN_AW, 10, training memory address width; max N_TRAIN = 2^TRAIN_AW.
- TEST_AW, 8, test memory address width; max N_TEST = 2^TEST_AW.
- DRAIN_CYC, 2, cycles to wait after the last valid before Neighbour_info is stable (list insertion latency).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- go  in  1  start batch; sampled only in IDLE
- n_train  in  TRAIN_AW+1  training point count, latched at go
- n_test  in  TEST_AW+1  test point count, latched at go
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the batch completes
- te_en  out  1  test memory read enable
- te_addr  out  TEST_AW  test memory address
- te_data  in  DATA_W  test memory data, 1-cycle read latency
- tr_en  out  1  training memory read enable
- tr_addr  out  TRAIN_AW  training memory address
- tr_data  in  DATA_W  training memory data, 1-cycle read latency
- tr_label  in  LABEL  training label, 1-cycle read latency
- knn_A  out  DATA_W  test point to core
- knn_B  out  DATA_W  training point to core
- knn_label  out  LABEL  training label to core
- knn_valid  out  1  candidate valid to core
- knn_start  out  1  list clear to core
- res_valid  out  1  Neighbour_info stable for test res_idx
- res_ready  in  1  consumer accepts result
- res_idx  out  TEST_AW  index of current test point

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and latched counts 0. Reset mid-operation abandons the batch with no done pulse.
- IDLE: on go=1, latch n_train and n_test; clear t=0.
  - If either count is 0: next state FINISH, with no memory or core activity.
  - Otherwise: next state LOAD.
  - go while busy is ignored.
- LOAD (1 cycle): te_en=1, te_addr=t. Next state CLEAR.
- CLEAR (1 cycle): knn_A <= te_data, registered and held until the next LOAD completes; knn_start=1; tr_en=1, tr_addr=0; i=1. Next state STREAM.
- STREAM:
  - Each cycle with i<n_train: tr_en=1, tr_addr=i, i++.
  - knn_valid is tr_en delayed 1 cycle. knn_B and knn_label are tr_data and tr_label, passed combinationally and gated to 0 when knn_valid=0.
  - Exactly n_train consecutive valid cycles, the first one the cycle after knn_start.
  - Leave to DRAIN on the cycle the last valid is presented.
- DRAIN: counter runs DRAIN_CYC cycles with no valid, then goes to RESULT. DRAIN_CYC=0 goes straight to RESULT.
- RESULT: res_valid=1, res_idx=t, held until res_ready=1.
  - On the handshake cycle: t++.
  - If t+1==n_test: FINISH. Otherwise: LOAD.
  - res_ready while res_valid=0 has no effect.
- FINISH (1 cycle): done=1, busy=0 from the next cycle, return to IDLE.
- Counters are one bit wider than the address widths so that full-size counts (2^AW) terminate correctly; addresses use the low bits, with no wrap.
- Per-test latency from LOAD to res_valid: 3 + n_train + DRAIN_CYC cycles (n_train>=1).
- knn_start and knn_valid are never high in the same cycle.

Decomposition:
- Shared package knn_pkg:
  - state encoding (IDLE, LOAD, CLEAR, STREAM, DRAIN, RESULT, FINISH)
  - DATA_W and LABEL defaults
  - x/y field slice constants
- Sub-module knn_sched_ctr: loadable up-counter with terminal-count compare, instantiated for i, t and the drain counter.
- knn_sched is instantiated alongside knn_core by the top-level wrapper. knn_core's Neighbour_info goes straight to the consumer, qualified by res_valid.

Test Plan:
- Single test, n_train=3, n_test=1, DRAIN_CYC=2, res_ready=1:
  - knn_start in cycle 2 after go, knn_valid in cycles 3,4,5 with B = mem[0..2].
  - res_valid in cycle 8; done in cycle 9.
- n_test=2, res_ready held low 4 cycles on the first result:
  - res_valid holds with res_idx=0; no te_en until the handshake.
  - Second burst follows, res_idx=1; exactly one done.
- n_train=0 or n_test=0: done one cycle after go; te_en, tr_en, knn_start and knn_valid never assert.
- Async rst pulled low during STREAM (i=2 of 5): all outputs 0 immediately. A later go restarts the burst from tr_addr=0 and knn_start.
- go pulsed while busy and during RESULT: ignored; counts unchanged; single done.
- Full sizes n_train=2^TRAIN_AW, n_test=1: 1024 contiguous valids, last tr_addr=1023, no wrap; result then done.
